// File: rtl/layer_sequencer.sv
// ============================================================================
// Module   : layer_sequencer
// Brief    : Instruction-driven CNN layer controller; gates output-buffer writes
//            from the selected result source and reports layer/network completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_sequencer #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int MODE_WIDTH        = 2,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_signal,
    input  logic                         abort,
    input  logic                         ready_write_from_activation,
    input  logic                         ready_write_from_pooling,
    output logic [MODE_WIDTH-1:0]        layer_mode,
    output logic                         fully_convol_signal,
    output logic                         pooling_signal,
    output logic                         write_signal,
    output logic [COUNT_WIDTH-1:0]       write_count,
    output logic                         busy,
    output logic                         layer_done,
    output logic                         net_done,
    output logic                         err_illegal
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_last;

    logic [MODE_WIDTH-1:0]  w_mode_field;
    logic [COUNT_WIDTH-1:0] w_count_field;
    logic                   w_last_field;
    logic                   w_mode_legal;
    logic                   w_sel_ready;
    logic [COUNT_WIDTH-1:0] w_count_inc;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_write;
    logic                   w_unused_instr;

    assign w_mode_field   = instruction_signal[MODE_WIDTH-1:0];
    assign w_count_field  = instruction_signal[MODE_WIDTH+COUNT_WIDTH-1:MODE_WIDTH];
    assign w_last_field   = instruction_signal[INSTRUCTION_WIDTH-1];
    // Bits between the count field and LAST are reserved.
    assign w_unused_instr = &{1'b0, instruction_signal};

    assign w_mode_legal = (w_mode_field == MODE_WIDTH'(0)) || (w_mode_field == MODE_WIDTH'(1));
    assign w_count_inc  = write_count + COUNT_WIDTH'(1);

    // Only the source matching the latched mode can trigger a write.
    assign w_sel_ready = (layer_mode == MODE_WIDTH'(0)) ? ready_write_from_activation :
                         (layer_mode == MODE_WIDTH'(1)) ? ready_write_from_pooling    : 1'b0;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (instr_valid) begin
                    if (w_mode_legal && (w_count_field != '0)) begin
                        w_accept     = 1'b1;
                        w_state_next = c_S_RUN;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            c_S_RUN: begin
                if (abort) begin
                    w_state_next = c_S_IDLE;
                end else if (w_sel_ready && (write_count != r_count)) begin
                    w_write = 1'b1;
                    if (w_count_inc == r_count) begin
                        w_state_next = c_S_DONE;
                    end
                end
            end
            c_S_DONE: w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    // Status outputs are registered copies of the next state, so layer_done
    // coincides with the final write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state             <= c_S_IDLE;
            r_count             <= '0;
            r_last              <= 1'b0;
            instr_ready         <= 1'b1;
            layer_mode          <= '0;
            fully_convol_signal <= 1'b1;
            pooling_signal      <= 1'b0;
            write_signal        <= 1'b0;
            write_count         <= '0;
            busy                <= 1'b0;
            layer_done          <= 1'b0;
            net_done            <= 1'b0;
            err_illegal         <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            instr_ready  <= (w_state_next == c_S_IDLE);
            busy         <= (w_state_next != c_S_IDLE);
            write_signal <= w_write;
            err_illegal  <= w_reject;
            layer_done   <= (w_state_next == c_S_DONE);
            net_done     <= (w_state_next == c_S_DONE) && r_last;
            if (w_accept) begin
                r_count             <= w_count_field;
                r_last              <= w_last_field;
                layer_mode          <= w_mode_field;
                fully_convol_signal <= (w_mode_field == MODE_WIDTH'(0));
                pooling_signal      <= (w_mode_field == MODE_WIDTH'(1));
                write_count         <= '0;
            end else if (w_write) begin
                write_count <= w_count_inc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// ============================================================================
// Module   : tb_layer_sequencer
// Brief    : Directed self-checking bench for layer_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        abort;
    logic        act_rdy;
    logic        pool_rdy;
    logic [1:0]  layer_mode;
    logic        fully_convol_signal;
    logic        pooling_signal;
    logic        write_signal;
    logic [15:0] write_count;
    logic        busy;
    logic        layer_done;
    logic        net_done;
    logic        err_illegal;

    int passes = 0;
    int total  = 0;

    layer_sequencer #(
        .INSTRUCTION_WIDTH(32),
        .MODE_WIDTH(2),
        .COUNT_WIDTH(16)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .instr_valid                (instr_valid),
        .instr_ready                (instr_ready),
        .instruction_signal         (instr),
        .abort                      (abort),
        .ready_write_from_activation(act_rdy),
        .ready_write_from_pooling   (pool_rdy),
        .layer_mode                 (layer_mode),
        .fully_convol_signal        (fully_convol_signal),
        .pooling_signal             (pooling_signal),
        .write_signal               (write_signal),
        .write_count                (write_count),
        .busy                       (busy),
        .layer_done                 (layer_done),
        .net_done                   (net_done),
        .err_illegal                (err_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk(input logic [1:0] m, input logic [15:0] c, input logic l);
        return {l, 13'd0, c, m};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, instr_ready, 1);
        chk({tag, "_mode"},  layer_mode, 0);
        chk({tag, "_fc"},    fully_convol_signal, 1);
        chk({tag, "_pool"},  pooling_signal, 0);
        chk({tag, "_ws"},    write_signal, 0);
        chk({tag, "_wc"},    write_count, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_ld"},    layer_done, 0);
        chk({tag, "_nd"},    net_done, 0);
        chk({tag, "_err"},   err_illegal, 0);
    endtask

    initial begin
        logic       prev_pool;
        logic       exp_ws;
        int         exp_wc;

        rst = 1'b1; instr_valid = 1'b0; instr = '0; abort = 1'b0;
        act_rdy = 1'b0; pool_rdy = 1'b0;
        step(); step();
        chk_reset_values("reset");
        rst = 1'b0;
        step();

        // 1: fully-connected layer, count 4, activation held high
        instr_valid = 1'b1; instr = mk(2'd0, 16'd4, 1'b0); act_rdy = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_ready_low", instr_ready, 0);
        chk("t1_ws_first", write_signal, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t1_ws", write_signal, 1);
            chk("t1_wc", write_count, i);
            chk("t1_ld", layer_done, (i == 4) ? 1 : 0);
            chk("t1_nd", net_done, 0);
            chk("t1_fc", fully_convol_signal, 1);
        end
        act_rdy = 1'b0;
        step();
        chk("t1_ws_end", write_signal, 0);
        chk("t1_ld_end", layer_done, 0);
        chk("t1_ready_end", instr_ready, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_wc_hold", write_count, 4);

        // 2: pooling layer, count 3, LAST, pooling ready toggling
        instr_valid = 1'b1; instr = mk(2'd1, 16'd3, 1'b1); act_rdy = 1'b1; pool_rdy = 1'b0;
        step();
        instr_valid = 1'b0;
        chk("t2_mode", layer_mode, 1);
        chk("t2_pool", pooling_signal, 1);
        chk("t2_fc", fully_convol_signal, 0);
        pool_rdy = 1'b1; prev_pool = 1'b1; exp_wc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_ws = prev_pool && (exp_wc < 3);
            if (exp_ws) exp_wc++;
            chk("t2_ws", write_signal, exp_ws);
            chk("t2_ld", layer_done, (exp_ws && exp_wc == 3) ? 1 : 0);
            chk("t2_nd", net_done, (exp_ws && exp_wc == 3) ? 1 : 0);
            pool_rdy = ~pool_rdy; prev_pool = pool_rdy;
        end
        act_rdy = 1'b0; pool_rdy = 1'b0;
        chk("t2_wc", write_count, 3);
        chk("t2_mode_hold", layer_mode, 1);
        chk("t2_pool_hold", pooling_signal, 1);

        // 3: illegal instructions
        instr_valid = 1'b1; instr = mk(2'd3, 16'd5, 1'b0);
        step();
        chk("t3_err_mode", err_illegal, 1);
        chk("t3_busy_mode", busy, 0);
        chk("t3_ready_mode", instr_ready, 1);
        chk("t3_lm_mode", layer_mode, 1);
        instr = mk(2'd0, 16'd0, 1'b0);
        step();
        chk("t3_err_cnt", err_illegal, 1);
        chk("t3_busy_cnt", busy, 0);
        chk("t3_lm_cnt", layer_mode, 1);
        instr_valid = 1'b0;
        step();
        chk("t3_err_clr", err_illegal, 0);

        // 4: abort on the third ready of a count-5 layer
        instr_valid = 1'b1; instr = mk(2'd0, 16'd5, 1'b0);
        step();
        instr_valid = 1'b0;
        chk("t4_wc_clr", write_count, 0);
        act_rdy = 1'b1;
        step();
        chk("t4_wc1", write_count, 1);
        step();
        chk("t4_wc2", write_count, 2);
        abort = 1'b1;
        step();
        abort = 1'b0; act_rdy = 1'b0;
        chk("t4_ws_abort", write_signal, 0);
        chk("t4_wc_abort", write_count, 2);
        chk("t4_busy_abort", busy, 0);
        chk("t4_ld_abort", layer_done, 0);
        chk("t4_ready_abort", instr_ready, 1);
        instr_valid = 1'b1; instr = mk(2'd0, 16'd1, 1'b1);
        step();
        instr_valid = 1'b0;
        chk("t4_next_busy", busy, 1);
        chk("t4_next_wc", write_count, 0);
        act_rdy = 1'b1;
        step();
        act_rdy = 1'b0;
        chk("t4_next_ws", write_signal, 1);
        chk("t4_next_ld", layer_done, 1);
        chk("t4_next_nd", net_done, 1);
        step();

        // 5: instr_valid held through a count-2 layer
        instr_valid = 1'b1; instr = mk(2'd0, 16'd2, 1'b0); act_rdy = 1'b1;
        step();
        chk("t5_acc_busy", busy, 1);
        chk("t5_acc_ready", instr_ready, 0);
        step();
        chk("t5_run_wc", write_count, 1);
        chk("t5_run_ready", instr_ready, 0);
        step();
        act_rdy = 1'b0;
        chk("t5_done_wc", write_count, 2);
        chk("t5_done_ld", layer_done, 1);
        chk("t5_done_ready", instr_ready, 0);
        step();
        chk("t5_idle_ready", instr_ready, 1);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_wc", write_count, 2);
        step();
        instr_valid = 1'b0;
        chk("t5_acc2_busy", busy, 1);
        chk("t5_acc2_wc", write_count, 0);
        act_rdy = 1'b1;
        step(); step();
        act_rdy = 1'b0;
        chk("t5_l2_wc", write_count, 2);
        chk("t5_l2_ld", layer_done, 1);
        step();

        // 6: asynchronous reset mid-RUN
        instr_valid = 1'b1; instr = mk(2'd0, 16'd10, 1'b1);
        step();
        instr_valid = 1'b0; act_rdy = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("t6_wc7", write_count, 7);
        #2 rst = 1'b1;
        #1;
        chk_reset_values("t6_rst");
        #1 rst = 1'b0;
        act_rdy = 1'b0;
        step();
        chk("t6_after_ld", layer_done, 0);
        chk("t6_after_busy", busy, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
